// File: rtl/led_bank_pkg.sv
// Shared constants for led_bank: channel mode encodings, register word indices and a
// byte-strobe helper used by the bus write path.
package led_bank_pkg;

  localparam logic [2:0] ModeOff    = 3'd0;
  localparam logic [2:0] ModeOn     = 3'd1;
  localparam logic [2:0] ModeBlink  = 3'd2;
  localparam logic [2:0] ModePwm    = 3'd3;
  localparam logic [2:0] ModeRandom = 3'd4;

  localparam logic [5:0] WordCtrl   = 6'd0;
  localparam logic [5:0] WordDiv    = 6'd1;
  localparam logic [5:0] WordStatus = 6'd2;
  localparam logic [5:0] WordChBase = 6'd8;

  function automatic logic [31:0] strb_mask(logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  function automatic logic [31:0] ch_word(logic [2:0] mode, logic [7:0] duty);
    return {16'h0000, duty, 5'b00000, mode};
  endfunction

endpackage

// File: rtl/led_bank_if.sv
// picorv32 native-bus slice seen by led_bank, including the memory_decoder chip select.
interface led_bank_if;
  logic        enable;
  logic        mem_valid;
  logic        mem_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output enable, mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  enable, mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/led_prescaler.sv
// Programmable tick generator: counts 0..div_i and pulses tick_o on the terminal count.
// The counter is held at 0 while disabled and cleared whenever a new divider is loaded.
module led_prescaler #(
  parameter int unsigned DIV_WIDTH = 24
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  // The tick of the current cycle is still emitted when a load lands on it.
  assign tick_o = en_i & (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q + DIV_WIDTH'(1);
    if (!en_i || load_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_bank.sv
// led_bank: memory-mapped multi-channel LED driver (OFF/ON/BLINK/PWM/RANDOM per channel).
// Define LED_BANK_RANDOM_EN to build the RANDOM mode and its per-channel latches.
module led_bank
  import led_bank_pkg::*;
#(
  parameter int unsigned CHANNELS  = 8,
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned DIV_RESET = 2_499_999
) (
  input  logic                clk,
  input  logic                reset,
  led_bank_if.slave           bus,
  input  logic [CHANNELS-1:0] rnd_in,
  output logic [CHANNELS-1:0] leds,
  output logic                tick
);

  logic [5:0]           word_idx;
  logic                 req, wr, rd;
  logic                 ready_q;
  logic [31:0]          rdata_q, rdata_d;
  logic                 en_q, en_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 div_load;
  logic [31:0]          div_merged;
  logic [7:0]           pwm_q, pwm_d;
  logic [2:0]           mode_q [CHANNELS];
  logic [2:0]           mode_d [CHANNELS];
  logic [7:0]           duty_q [CHANNELS];
  logic [7:0]           duty_d [CHANNELS];
  logic [CHANNELS-1:0]  ch_wr;
  logic [CHANNELS-1:0]  blink_q, blink_d;
  logic [CHANNELS-1:0]  leds_q, leds_d;
  logic                 unused_bits;

  assign word_idx = bus.mem_addr[7:2];
  assign req      = bus.mem_valid & bus.enable & ~ready_q;
  assign wr       = req & (|bus.mem_wstrb);
  assign rd       = req & ~(|bus.mem_wstrb);

  assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata, div_merged, rnd_in};

  led_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (en_q),
    .load_i (div_load),
    .div_i  (div_q),
    .tick_o (tick)
  );

  // Control and divider registers, merged byte by byte.
  assign div_merged = (32'(div_q) & ~strb_mask(bus.mem_wstrb)) |
                      (bus.mem_wdata & strb_mask(bus.mem_wstrb));

  always_comb begin
    en_d     = en_q;
    div_d    = div_q;
    div_load = 1'b0;
    if (wr && word_idx == WordCtrl && bus.mem_wstrb[0]) begin
      en_d = bus.mem_wdata[0];
    end
    if (wr && word_idx == WordDiv) begin
      div_d    = div_merged[DIV_WIDTH-1:0];
      div_load = 1'b1;
    end
  end

  assign pwm_d = en_q ? pwm_q + 8'd1 : 8'd0;

  always_comb begin
    ch_wr = '0;
    for (int n = 0; n < int'(CHANNELS); n++) begin
      mode_d[n] = mode_q[n];
      duty_d[n] = duty_q[n];
      ch_wr[n]  = wr && (word_idx == WordChBase + 6'(n));
      if (ch_wr[n] && bus.mem_wstrb[0]) begin
        mode_d[n] = bus.mem_wdata[2:0];
      end
      if (ch_wr[n] && bus.mem_wstrb[1]) begin
        duty_d[n] = bus.mem_wdata[15:8];
      end
    end
  end

  // A channel write wins over a coincident tick.
  assign blink_d = (tick ? ~blink_q : blink_q) & ~ch_wr;

`ifdef LED_BANK_RANDOM_EN
  logic [CHANNELS-1:0] rnd_q, rnd_d;

  assign rnd_d = (tick ? rnd_in : rnd_q) & ~ch_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rnd_q <= '0;
    end else begin
      rnd_q <= rnd_d;
    end
  end
`endif

  always_comb begin
    leds_d = '0;
    for (int n = 0; n < int'(CHANNELS); n++) begin
      if (en_q) begin
        case (mode_q[n])
          ModeOn:     leds_d[n] = 1'b1;
          ModeBlink:  leds_d[n] = blink_q[n];
          ModePwm:    leds_d[n] = pwm_q < duty_q[n];
`ifdef LED_BANK_RANDOM_EN
          ModeRandom: leds_d[n] = rnd_q[n];
`endif
          default:    leds_d[n] = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      if (word_idx == WordCtrl) begin
        rdata_d = {31'h0, en_q};
      end else if (word_idx == WordDiv) begin
        rdata_d = 32'(div_q);
      end else if (word_idx == WordStatus) begin
        rdata_d = 32'(leds_q);
      end
      for (int n = 0; n < int'(CHANNELS); n++) begin
        if (word_idx == WordChBase + 6'(n)) begin
          rdata_d = ch_word(mode_q[n], duty_q[n]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      div_q   <= DIV_WIDTH'(DIV_RESET);
      pwm_q   <= '0;
      blink_q <= '0;
      leds_q  <= '0;
      for (int n = 0; n < int'(CHANNELS); n++) begin
        mode_q[n] <= '0;
        duty_q[n] <= '0;
      end
    end else begin
      ready_q <= req;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      div_q   <= div_d;
      pwm_q   <= pwm_d;
      blink_q <= blink_d;
      leds_q  <= leds_d;
      for (int n = 0; n < int'(CHANNELS); n++) begin
        mode_q[n] <= mode_d[n];
        duty_q[n] <= duty_d[n];
      end
    end
  end

  assign leds          = leds_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_led_bank.sv
// Self-checking bench for led_bank: randomized register traffic and timed mode checks
// against a cycle-indexed arithmetic model of ticks, blink, PWM and random latches.
module tb_led_bank;
  localparam int unsigned Ch       = 8;
  localparam int unsigned DivReset = 2_499_999;

  logic          clk = 1'b0;
  logic          reset;
  logic [Ch-1:0] rnd_in;
  logic [Ch-1:0] leds;
  logic          tick;

  led_bank_if bus_if ();

  led_bank #(
    .CHANNELS (Ch),
    .DIV_WIDTH(24),
    .DIV_RESET(DivReset)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .rnd_in(rnd_in),
    .leds  (leds),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents plus the edge indices at which phases restart.
  bit          m_en;
  int          m_div;
  int          t_base;
  int          t_en;
  int          w0;
  bit [2:0]    m_mode [Ch];
  bit [7:0]    m_duty [Ch];
  logic [Ch-1:0] exp_static;

  function automatic bit tick_at(int c);
    if (!m_en || c < t_base) return 1'b0;
    return ((c - t_base) % (m_div + 1)) == m_div;
  endfunction

  function automatic bit blink_after(int e);
    int t = 0;
    for (int k = w0 + 1; k <= e; k++) if (tick_at(k - 1)) t++;
    return t[0];
  endfunction

  function automatic void model_reset();
    m_en = 1'b0;
    m_div = DivReset;
    for (int n = 0; n < Ch; n++) begin
      m_mode[n] = 3'd0;
      m_duty[n] = 8'd0;
    end
  endfunction

  function automatic void model_ch_write(int n, logic [31:0] d, logic [3:0] s);
    if (s[0]) m_mode[n] = d[2:0];
    if (s[1]) m_duty[n] = d[15:8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.enable    = 1'b0;
    bus_if.mem_valid = 1'b0;
    bus_if.mem_addr  = 8'h00;
    bus_if.mem_wdata = 32'h0;
    bus_if.mem_wstrb = 4'h0;
  endtask

  task automatic bus_write(input logic [5:0] word, input logic [31:0] data,
                           input logic [3:0] strb, output int commit);
    bit got = 1'b0;
    commit = cyc;
    bus_if.enable    = 1'b1;
    bus_if.mem_valid = 1'b1;
    bus_if.mem_addr  = {word, 2'b00};
    bus_if.mem_wdata = data;
    bus_if.mem_wstrb = strb;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      if (bus_if.mem_ready === 1'b1) begin
        got = 1'b1;
        commit = cyc;
      end
    end
    bus_idle();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL write_ready word=%0d: mem_ready stayed low, required a pulse within 4 clks",
               word);
    end
  endtask

  task automatic bus_read(input logic [5:0] word, output logic [31:0] data);
    bit got = 1'b0;
    data = 32'h0;
    bus_if.enable    = 1'b1;
    bus_if.mem_valid = 1'b1;
    bus_if.mem_addr  = {word, 2'b00};
    bus_if.mem_wstrb = 4'h0;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      if (bus_if.mem_ready === 1'b1) begin
        got = 1'b1;
        data = bus_if.mem_rdata;
      end
    end
    bus_idle();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL read_ready word=%0d: mem_ready stayed low, required a pulse within 4 clks",
               word);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    rnd_in = '0;
    bus_idle();
    repeat (3) step();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (bus_if.mem_ready !== 1'b0 || leds !== '0 || tick !== 1'b0 ||
          bus_if.mem_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_idle: ready=%b leds=%h tick=%b rdata=%h, required all 0",
                 bus_if.mem_ready, leds, tick, bus_if.mem_rdata);
      end
    end
    bus_read(6'd0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h, required 0", d); end
    bus_read(6'd1, d);
    n_checks++;
    if (d !== 32'(DivReset)) begin
      n_fail++;
      $display("FAIL reset_div: got %0d, required %0d", d, DivReset);
    end
    bus_read(6'd2, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h, required 0", d); end
    step();
    n_checks++;
    if (bus_if.mem_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rdata_idle: got %h, required 0 outside mem_ready", bus_if.mem_rdata);
    end
  endtask

  task automatic test_blink();
    int c;
    bus_write(6'd1, 32'd3, 4'hF, c);
    m_div = 3;
    bus_write(6'd0, 32'd1, 4'h1, c);
    m_en = 1'b1; t_base = c; t_en = c;
    bus_write(6'd8, 32'h0000_0002, 4'h3, c);
    model_ch_write(0, 32'h2, 4'h3);
    w0 = c;
    for (int i = 0; i < 40; i++) begin
      step();
      n_checks++;
      if (tick !== tick_at(cyc)) begin
        n_fail++;
        $display("FAIL blink_tick cyc=%0d: got %b, required %b", cyc, tick, tick_at(cyc));
      end
      n_checks++;
      if (leds[0] !== blink_after(cyc - 1)) begin
        n_fail++;
        $display("FAIL blink_led cyc=%0d: got %b, required %b", cyc, leds[0],
                 blink_after(cyc - 1));
      end
    end
  endtask

  task automatic test_tick_collision();
    int c;
    int guard = 0;
    // Aim the write at a toggle edge where blink_q would otherwise rise to 1.
    while (!(tick_at(cyc) && !blink_after(cyc)) && guard < 32) begin
      step();
      guard++;
    end
    n_checks++;
    if (tick !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_tick: got %b, required 1 in the write cycle", tick);
    end
    bus_write(6'd8, 32'h0000_0002, 4'h1, c);
    w0 = c;
    step();
    n_checks++;
    if (leds[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_clear: got %b, required 0 (write beats tick)", leds[0]);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (leds[0] !== blink_after(cyc - 1)) begin
        n_fail++;
        $display("FAIL collision_led cyc=%0d: got %b, required %b", cyc, leds[0],
                 blink_after(cyc - 1));
      end
    end
  endtask

  task automatic test_pwm();
    int          duties [4];
    int          c, highs, bad;
    logic [31:0] r, d;
    bit          e;
    duties[0] = 64;
    duties[1] = 0;
    duties[2] = 255;
    duties[3] = int'($urandom_range(1, 254));
    foreach (duties[j]) begin
      r = $urandom;
      d = {r[31:16], 8'(duties[j]), r[7:3], 3'd3};
      bus_write(6'd9, d, 4'b0011, c);
      model_ch_write(1, d, 4'b0011);
      step();
      highs = 0;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        e = ((cyc - 1 - t_en) % 256) < duties[j];
        if (leds[1] === 1'b1) highs++;
        if (leds[1] !== e) bad++;
        step();
      end
      n_checks++;
      if (highs != duties[j]) begin
        n_fail++;
        $display("FAIL pwm_count duty=%0d: got %0d high clks, required %0d", duties[j], highs,
                 duties[j]);
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL pwm_phase duty=%0d: got %0d wrong clks, required 0", duties[j], bad);
      end
    end
  endtask

  task automatic test_random();
    logic [Ch-1:0] vals [3];
    logic [31:0]   r;
    int            c;
    bit            seen, e;
    r = $urandom;
    vals[0] = 8'h04;
    vals[1] = 8'hFB;
    vals[2] = r[7:0];
    foreach (vals[j]) begin
      rnd_in = vals[j];
      bus_write(6'd10, 32'h0000_0004, 4'h1, c);
      for (int i = 0; i < 16; i++) begin
        step();
        seen = 1'b0;
        for (int k = c + 1; k <= cyc - 1; k++) if (tick_at(k - 1)) seen = 1'b1;
`ifdef LED_BANK_RANDOM_EN
        e = seen & vals[j][2];
`else
        e = 1'b0;
`endif
        n_checks++;
        if (leds[2] !== e) begin
          n_fail++;
          $display("FAIL random_led rnd=%h cyc=%0d: got %b, required %b", vals[j], cyc,
                   leds[2], e);
        end
      end
    end
  endtask

  task automatic test_byte_strobe();
    int          c;
    logic [31:0] d;
    bus_write(6'd11, 32'h0000_1101, 4'hF, c);
    model_ch_write(3, 32'h0000_1101, 4'hF);
    bus_write(6'd11, 32'hFFFF_ABFE, 4'b0010, c);
    model_ch_write(3, 32'hFFFF_ABFE, 4'b0010);
    bus_read(6'd11, d);
    n_checks++;
    if (d !== {16'h0, m_duty[3], 5'h0, m_mode[3]}) begin
      n_fail++;
      $display("FAIL strobe_ch3: got %h, required %h", d, {16'h0, m_duty[3], 5'h0, m_mode[3]});
    end
    n_checks++;
    if (leds[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL strobe_led3: got %b, required 1 (mode ON kept)", leds[3]);
    end
    bus_write(6'd5, 32'hFFFF_FFFF, 4'hF, c);
    step();
    n_checks++;
    if (bus_if.mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_pulse: got %b one clk later, required 0", bus_if.mem_ready);
    end
    bus_read(6'd5, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_w5: got %h, required 0", d); end
    bus_read(6'd7, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_w7: got %h, required 0", d); end
    bus_read(6'(8 + Ch), d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_chend: got %h, required 0", d); end
    bus_read(6'd63, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_w63: got %h, required 0", d); end
  endtask

  task automatic test_regs_random();
    int          c, n;
    logic [31:0] d, r;
    logic [3:0]  s;
    bit [2:0]    statics [5];
    statics[0] = 3'd0; statics[1] = 3'd1; statics[2] = 3'd5;
    statics[3] = 3'd6; statics[4] = 3'd7;
    for (int i = 0; i < 24; i++) begin
      n = int'($urandom_range(0, Ch - 1));
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      bus_write(6'(8 + n), d, s, c);
      model_ch_write(n, d, s);
      n = int'($urandom_range(0, Ch - 1));
      bus_read(6'(8 + n), r);
      n_checks++;
      if (r !== {16'h0, m_duty[n], 5'h0, m_mode[n]}) begin
        n_fail++;
        $display("FAIL regs_ch%0d: got %h, required %h", n, r,
                 {16'h0, m_duty[n], 5'h0, m_mode[n]});
      end
    end
    bus_read(6'd1, r);
    n_checks++;
    if (r !== 32'(m_div)) begin n_fail++; $display("FAIL regs_div: got %h, required %h", r, m_div); end
    bus_read(6'd0, r);
    n_checks++;
    if (r !== 32'(m_en)) begin n_fail++; $display("FAIL regs_ctrl: got %h, required %h", r, m_en); end
    for (int k = 0; k < Ch; k++) begin
      r = $urandom;
      d = {r[31:8], r[7:3], statics[$urandom_range(0, 4)]};
      bus_write(6'(8 + k), d, 4'h1, c);
      model_ch_write(k, d, 4'h1);
      exp_static[k] = (m_mode[k] == 3'd1);
    end
    step();
    step();
    n_checks++;
    if (leds !== exp_static) begin
      n_fail++;
      $display("FAIL static_leds: got %h, required %h", leds, exp_static);
    end
    bus_read(6'd2, r);
    n_checks++;
    if (r !== 32'(exp_static)) begin
      n_fail++;
      $display("FAIL status_read: got %h, required %h", r, 32'(exp_static));
    end
  endtask

  task automatic test_disable();
    int          c, n;
    logic [31:0] r;
    bus_write(6'd0, 32'hFFFF_FFFE, 4'hF, c);
    m_en = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (leds !== '0 || tick !== 1'b0) begin
        n_fail++;
        $display("FAIL disabled_out: leds=%h tick=%b, required 0 and 0", leds, tick);
      end
      step();
    end
    bus_read(6'd0, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL disabled_ctrl: got %h, required 0", r); end
    n = int'($urandom_range(0, Ch - 1));
    bus_read(6'(8 + n), r);
    n_checks++;
    if (r !== {16'h0, m_duty[n], 5'h0, m_mode[n]}) begin
      n_fail++;
      $display("FAIL disabled_keep_ch%0d: got %h, required %h", n, r,
               {16'h0, m_duty[n], 5'h0, m_mode[n]});
    end
    bus_write(6'd0, 32'h0000_0001, 4'h1, c);
    m_en = 1'b1; t_base = c; t_en = c;
    step();
    step();
    n_checks++;
    if (leds !== exp_static) begin
      n_fail++;
      $display("FAIL reenable_leds: got %h, required %h", leds, exp_static);
    end
  endtask

  task automatic test_div_zero();
    int          c;
    int          guard = 0;
    logic [31:0] r;
    while (!tick_at(cyc) && guard < 16) begin
      step();
      guard++;
    end
    n_checks++;
    if (tick !== 1'b1) begin
      n_fail++;
      $display("FAIL divload_tick: got %b, required 1 in the DIV write cycle", tick);
    end
    bus_write(6'd1, 32'h0, 4'hF, c);
    m_div = 0; t_base = c;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (tick !== tick_at(cyc)) begin
        n_fail++;
        $display("FAIL div0_tick cyc=%0d: got %b, required %b", cyc, tick, tick_at(cyc));
      end
      step();
    end
    bus_read(6'd1, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL div0_read: got %h, required 0", r); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] r;
    bus_if.enable    = 1'b1;
    bus_if.mem_valid = 1'b1;
    bus_if.mem_addr  = {6'd13, 2'b00};
    bus_if.mem_wdata = 32'h0000_FF01;
    bus_if.mem_wstrb = 4'hF;
    reset = 1'b1;
    step();
    n_checks++;
    if (bus_if.mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ready: got %b, required 0", bus_if.mem_ready);
    end
    bus_idle();
    step();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus_if.mem_ready !== 1'b0 || leds !== '0) begin
        n_fail++;
        $display("FAIL midreset_idle: ready=%b leds=%h, required 0 and 0", bus_if.mem_ready,
                 leds);
      end
    end
    bus_read(6'd13, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL midreset_lost: got %h, required 0", r); end
    bus_read(6'd1, r);
    n_checks++;
    if (r !== 32'(DivReset)) begin
      n_fail++;
      $display("FAIL midreset_div: got %0d, required %0d", r, DivReset);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_blink();
    test_tick_collision();
    test_pwm();
    test_random();
    test_byte_strobe();
    test_regs_random();
    test_disable();
    test_div_zero();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_bank.md
# led_bank

Parametrised multi-channel LED driver for the DE0-Nano top level. It generalises the fixed divide-by-2^23 clock and the PRNG-to-LED hookup into one memory-mapped peripheral on the picorv32 native bus. It has one clock domain. A programmable tick, used as a clock enable, drives per-channel modes: OFF, ON, BLINK, PWM and optional RANDOM. It is selected by one `memory_decoder` enable line.

## Interface
- `CHANNELS`, default 8: number of LED outputs, 1..24.
- `DIV_WIDTH`, default 24: prescaler width in bits.
- `DIV_RESET`, default 2_499_999: divider reset value, giving a 20 Hz tick at 50 MHz.
- `clk` in 1: system clock (CLOCK_50).
- `reset` in 1: synchronous reset, active-high.
- `enable` in 1: chip select from `memory_decoder`.
- `mem_valid` in 1: bus request.
- `mem_ready` out 1: one-cycle acknowledge.
- `mem_addr` in 8: byte address; bits [7:2] select the word.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte strobes; 0 means read.
- `mem_rdata` out 32: read data, valid while `mem_ready`=1.
- `rnd_in` in CHANNELS: random bits from xoroshiro128plus.
- `leds` out CHANNELS: registered LED drive.
- `tick` out 1: single-cycle prescaler pulse.

## Operation
- Register map (word index):
  - 0 CTRL: bit0 EN; other bits read 0.
  - 1 DIV: bits [DIV_WIDTH-1:0].
  - 2 STATUS: read-only; reads the current `leds`.
  - 8+n CH[n]: bits [2:0] MODE, bits [15:8] DUTY.
  - Unmapped words read 0, and writes to them are ignored.
- Bus handshake: `mem_ready` pulses for one cycle, the cycle after `mem_valid & enable & !mem_ready`.
- Writes commit on the `mem_ready` edge. Byte strobes are honoured per byte.
- Prescaler:
  - `cnt` counts 0..DIV, then wraps to 0.
  - `tick`=1 in the cycle `cnt`==DIV.
  - DIV=0 gives `tick` every cycle.
  - A DIV write clears `cnt` on the same edge.
- PWM counter: 8-bit, advances every clk while EN=1, wraps 255→0.
- Modes, per channel:
  - 0 OFF: output 0.
  - 1 ON: output 1.
  - 2 BLINK: `blink_q` toggles on each tick.
  - 3 PWM: output `pwm_cnt < DUTY`. DUTY=0 is always off; DUTY=255 is on 255/256 of the time.
  - 4 RANDOM: `rnd_in[n]` is latched on tick.
  - 5..7: same as OFF.
- A write to CH[n] clears that channel's `blink_q` and random latch to 0.
- EN=0:
  - `cnt` and `pwm_cnt` are held at 0.
  - `tick`=0 and `leds`=0.
  - Channel registers and latches are retained.
- Reset clears everything to 0: EN, `cnt`, `pwm_cnt`, all CH registers, latches, `leds`, `tick`, `mem_ready` and `mem_rdata`. DIV is set to DIV_RESET.

## Timing
- `leds` are registered: a mode or state change appears one clk later.
- A tick at edge k changes BLINK/RANDOM outputs at edge k+1.
- The tick period is DIV+1 clks. The BLINK period is 2·(DIV+1).
- A write that coincides with a tick takes priority: a CH write clears `blink_q` even if that tick would have toggled it.
- A DIV write coinciding with `cnt`==DIV still emits that tick; `cnt` becomes 0.
- Reset asserted mid-transaction:
  - `mem_ready` stays 0.
  - The write is lost.
  - The master must reissue it.
- Reads are registered: `mem_rdata` is valid with `mem_ready` and 0 otherwise.

## Configuration
- `LED_BANK_RANDOM_EN` defined: MODE 4 is RANDOM, as above.
- `LED_BANK_RANDOM_EN` undefined:
  - MODE 4 behaves as OFF.
  - The random latches are not built.
  - `rnd_in` is ignored (the port stays, for a uniform top level).

## Structure
- Package `led_bank_pkg` holds:
  - mode constants (OFF/ON/BLINK/PWM/RANDOM);
  - word-index constants (CTRL=0, DIV=1, STATUS=2, CH_BASE=8).
- Sub-module `led_prescaler` contains the DIV counter and `tick` generation, with load-clear and EN hold.
- Everything else lives in `led_bank`: bus, register file, PWM counter and per-channel logic.

## Test plan
- Reset, then read CTRL, DIV, STATUS → 0, 2_499_999, 0; `leds`=0 and `mem_ready` stays low without `mem_valid`.
- Write DIV=3, CTRL=1, CH0 MODE=2 → `tick` every 4 clks; `leds[0]` toggles every 4 clks, starting 1 clk after the first tick.
- CH1 MODE=3 with DUTY=64 → `leds[1]` high for exactly 64 of each 256 clks; DUTY=0 → never high.
- With `LED_BANK_RANDOM_EN`, CH2 MODE=4, `rnd_in`=8'h04 held → `leds[2]`=1 one clk after the next tick. Without the macro → `leds[2]` stays 0.
- Write CH0 in the same cycle as a tick → `blink_q` ends at 0. Write DIV=0 → `tick` is constant 1.
- Byte write with `mem_wstrb`=4'b0010 to CH3 → only DUTY changes; MODE keeps its old value. Write to word 5 → ready pulses and reads return 0.
